// File: rtl/in_port_conditioner.sv
// Input port conditioner: per-bit 2-flop synchronizer, counter debouncer and
// sticky rising-edge flags that are cleared by a CPU read of the input port.
module in_port_conditioner #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          EDGE_MODE       = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             rd_strobe,
  output logic [WIDTH-1:0] port_data,
  output logic [WIDTH-1:0] level,
  output logic             rise_pending
);

  localparam int unsigned CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] level_nxt;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] sticky;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];

  // Two-stage synchronizer for the asynchronous pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce decision; any sample matching the held level restarts the count
  always_comb begin
    level_nxt = level;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != level[i]) begin
        if (cnt[i] == CNT_MAX) begin
          level_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
    rise = level_nxt & ~level;
  end

  // Debounced level and stability counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      level <= level_nxt;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // Sticky rise flags: a new rise wins over a same-cycle read clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky <= '0;
    end else begin
      sticky <= (sticky & ~{WIDTH{rd_strobe}}) | rise;
    end
  end

  // Port view selects levels or flags; summary of pending rises
  always_comb begin
    port_data    = EDGE_MODE ? sticky : level;
    rise_pending = |sticky;
  end

endmodule

// File: tb/tb_in_port_conditioner.sv
// Bench for in_port_conditioner: level view and edge view instances share stimulus,
// expected values are queued per cycle and compared one posedge later.
module tb_in_port_conditioner;

  logic       clk;
  logic       reset;
  logic [7:0] raw_in;
  logic       rd_strobe;
  logic [7:0] port0, level0, port1, level1;
  logic       rp0, rp1;

  typedef struct packed {
    logic [7:0] lvl;
    logic [7:0] stk;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;

  in_port_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .raw_in(raw_in), .rd_strobe(rd_strobe),
    .port_data(port0), .level(level0), .rise_pending(rp0)
  );

  in_port_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .raw_in(raw_in), .rd_strobe(rd_strobe),
    .port_data(port1), .level(level1), .rise_pending(rp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Hold reset with the given pins, release at a negedge: next posedge is posedge 0
  task automatic apply_reset(input logic [7:0] pins);
    @(negedge clk);
    reset = 1'b0; raw_in = pins; rd_strobe = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [33:0] obs, want;
    @(negedge clk);
    reset = 1'b0; raw_in = 8'hFF; rd_strobe = 1'b0;
    repeat (2) @(negedge clk);
    obs = {level0, level1, port0, port1, rp0, rp1}; total++;
    if (obs !== '0) begin
      bad++; $display("FAIL reset_hold got=%h want=0", obs);
    end
    reset = 1'b1;
    for (int p = 0; p <= 6; p++) begin
      e.lvl = (p >= 5) ? 8'hFF : 8'h00; e.stk = e.lvl; sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      want = {e.lvl, e.lvl, e.lvl, e.stk, |e.stk, |e.stk};
      obs  = {level0, level1, port0, port1, rp0, rp1}; total++;
      if (obs !== want) begin
        bad++; $display("FAIL reset_release p=%0d got=%h want=%h", p, obs, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_read_clear();
    exp_t e;
    logic [33:0] obs, want;
    for (int p = 0; p < 3; p++) begin
      rd_strobe = (p < 2);
      e.lvl = 8'hFF; e.stk = 8'h00; sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      want = {e.lvl, e.lvl, e.lvl, e.stk, |e.stk, |e.stk};
      obs  = {level0, level1, port0, port1, rp0, rp1}; total++;
      if (obs !== want) begin
        bad++; $display("FAIL read_clear p=%0d got=%h want=%h", p, obs, want);
      end
      @(negedge clk);
    end
    rd_strobe = 1'b0;
  endtask

  task automatic test_single_bit();
    exp_t e;
    logic [33:0] obs, want;
    apply_reset(8'h00);
    for (int p = 0; p <= 6; p++) begin
      raw_in = 8'h08;
      e.lvl = (p >= 5) ? 8'h08 : 8'h00; e.stk = e.lvl; sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      want = {e.lvl, e.lvl, e.lvl, e.stk, |e.stk, |e.stk};
      obs  = {level0, level1, port0, port1, rp0, rp1}; total++;
      if (obs !== want) begin
        bad++; $display("FAIL single_bit p=%0d got=%h want=%h", p, obs, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    logic [33:0] obs, want;
    apply_reset(8'h00);
    for (int p = 0; p <= 7; p++) begin
      raw_in = (p < 3) ? 8'h01 : 8'h00;
      e.lvl = 8'h00; e.stk = 8'h00; sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      want = {e.lvl, e.lvl, e.lvl, e.stk, |e.stk, |e.stk};
      obs  = {level0, level1, port0, port1, rp0, rp1}; total++;
      if (obs !== want) begin
        bad++; $display("FAIL glitch p=%0d got=%h want=%h", p, obs, want);
      end
      if (p == 4) begin
        total++;
        if (dut0.cnt[0] !== 2'd3) begin
          bad++; $display("FAIL glitch_peak_cnt got=%0d want=3", dut0.cnt[0]);
        end
      end
      @(negedge clk);
    end
    total++;
    if (dut0.cnt[0] !== 2'd0) begin
      bad++; $display("FAIL glitch_cnt_cleared got=%0d want=0", dut0.cnt[0]);
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    logic [33:0] obs, want;
    logic [8:0]  seq;
    seq = 9'b111101101;
    apply_reset(8'h00);
    for (int p = 0; p <= 11; p++) begin
      raw_in = 8'h00;
      raw_in[1] = (p < 9) ? seq[p] : 1'b1;
      e.lvl = (p >= 10) ? 8'h02 : 8'h00; e.stk = e.lvl; sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      want = {e.lvl, e.lvl, e.lvl, e.stk, |e.stk, |e.stk};
      obs  = {level0, level1, port0, port1, rp0, rp1}; total++;
      if (obs !== want) begin
        bad++; $display("FAIL bounce p=%0d got=%h want=%h", p, obs, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_read_vs_rise();
    exp_t e;
    logic [33:0] obs, want;
    apply_reset(8'h04);
    for (int p = 0; p <= 5; p++) begin
      e.lvl = (p >= 5) ? 8'h04 : 8'h00; e.stk = e.lvl; sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      want = {e.lvl, e.lvl, e.lvl, e.stk, |e.stk, |e.stk};
      obs  = {level0, level1, port0, port1, rp0, rp1}; total++;
      if (obs !== want) begin
        bad++; $display("FAIL rvr_setup p=%0d got=%h want=%h", p, obs, want);
      end
      @(negedge clk);
    end
    for (int q = 0; q <= 7; q++) begin
      raw_in = 8'h24;
      rd_strobe = (q == 5) || (q == 6);
      e.lvl = (q >= 5) ? 8'h24 : 8'h04;
      e.stk = (q < 5) ? 8'h04 : ((q == 5) ? 8'h20 : 8'h00);
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      want = {e.lvl, e.lvl, e.lvl, e.stk, |e.stk, |e.stk};
      obs  = {level0, level1, port0, port1, rp0, rp1}; total++;
      if (obs !== want) begin
        bad++; $display("FAIL read_vs_rise q=%0d got=%h want=%h", q, obs, want);
      end
      @(negedge clk);
    end
    rd_strobe = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [33:0] obs, want;
    apply_reset(8'h00);
    for (int p = 0; p <= 5; p++) begin
      raw_in = 8'h80;
      e.lvl = (p >= 5) ? 8'h80 : 8'h00; e.stk = e.lvl; sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      want = {e.lvl, e.lvl, e.lvl, e.stk, |e.stk, |e.stk};
      obs  = {level0, level1, port0, port1, rp0, rp1}; total++;
      if (obs !== want) begin
        bad++; $display("FAIL ar_setup p=%0d got=%h want=%h", p, obs, want);
      end
      @(negedge clk);
    end
    for (int q = 0; q <= 3; q++) begin
      raw_in = 8'h84;
      e.lvl = 8'h80; e.stk = 8'h80; sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      want = {e.lvl, e.lvl, e.lvl, e.stk, |e.stk, |e.stk};
      obs  = {level0, level1, port0, port1, rp0, rp1}; total++;
      if (obs !== want) begin
        bad++; $display("FAIL ar_count q=%0d got=%h want=%h", q, obs, want);
      end
      if (q < 3) @(negedge clk);
    end
    total++;
    if (dut0.cnt[2] !== 2'd2) begin
      bad++; $display("FAIL ar_midcount got=%0d want=2", dut0.cnt[2]);
    end
    #2;
    reset = 1'b0;
    #1;
    obs = {level0, level1, port0, port1, rp0, rp1}; total++;
    if (obs !== '0 || dut0.cnt[2] !== 2'd0) begin
      bad++; $display("FAIL ar_async_clear got=%h cnt2=%0d want=0", obs, dut0.cnt[2]);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int p = 0; p <= 5; p++) begin
      e.lvl = (p >= 5) ? 8'h84 : 8'h00; e.stk = e.lvl; sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      want = {e.lvl, e.lvl, e.lvl, e.stk, |e.stk, |e.stk};
      obs  = {level0, level1, port0, port1, rp0, rp1}; total++;
      if (obs !== want) begin
        bad++; $display("FAIL ar_restart p=%0d got=%h want=%h", p, obs, want);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; raw_in = 8'h00; rd_strobe = 1'b0;
    test_reset();
    test_read_clear();
    test_single_bit();
    test_glitch();
    test_bounce();
    test_read_vs_rise();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
